// File: rtl/bcd_mul_digit_if.sv
// Request/response bundle for the serial BCD digit multiplier.
// The master drives the operands and start; the slave returns product and status.
interface bcd_mul_digit_if #(
    parameter int DIGITS = 4
);
    logic                      start;
    logic [4*DIGITS-1:0]       a;
    logic [3:0]                m;
    logic [4*(DIGITS+1)-1:0]   p;
    logic                      busy;
    logic                      done;
    logic                      err;

    modport master (output start, a, m, input p, busy, done, err);
    modport slave  (input start, a, m, output p, busy, done, err);
endinterface

// File: rtl/bcd_mul_digit.sv
// Serial N-digit packed-BCD times one BCD digit multiplier.
// One product digit is produced per clock; done pulses when p and err are final.
module bcd_mul_digit #(
    parameter int DIGITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    bcd_mul_digit_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int            IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    logic [1:0]                state;
    logic [4*DIGITS-1:0]       a_q;
    logic [3:0]                m_q;
    logic [3:0]                carry;
    logic [IW-1:0]             idx;
    logic [4*(DIGITS+1)-1:0]   p_q;
    logic                      err_q;

    logic       bad;
    logic [3:0] digit;
    logic [6:0] t;
    logic [3:0] t_lo;
    logic [3:0] t_hi;

    // NOTE: bad gets its default before the loop, so no path leaves it unassigned (no latch).
    always_comb begin
        bad = (bus.m > 4'd9);
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.a[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
    end

    // Worst case 9*9 + 8 = 89, so the carry into the next digit never exceeds 8.
    always_comb begin
        digit = a_q[{idx, 2'b00} +: 4];
        t     = 7'(digit) * 7'(m_q) + 7'(carry);
        t_lo  = 4'(t % 7'd10);
        t_hi  = 4'(t / 7'd10);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            m_q   <= '0;
            carry <= '0;
            idx   <= '0;
            p_q   <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q   <= bus.a;
                        m_q   <= bus.m;
                        p_q   <= '0;
                        carry <= '0;
                        idx   <= '0;
                        err_q <= bad;
                        state <= bad ? DONE : CALC;
                    end
                end
                CALC: begin
                    p_q[{idx, 2'b00} +: 4] <= t_lo;
                    carry                  <= t_hi;
                    if (idx == LAST) begin
                        p_q[4*DIGITS +: 4] <= t_hi;
                        state              <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.p    = p_q;
    assign bus.err  = err_q;
    assign bus.busy = (state != IDLE);
    assign bus.done = (state == DONE);
endmodule
